// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sequencer.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_WRAP_W = 4;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter pin levels while the sequencer leaves the counter alone
  localparam logic IDLE_CLR = 1'b1;
  localparam logic IDLE_LD  = 1'b1;
  localparam logic IDLE_M   = 1'b1;

endpackage

// File: rtl/counter_ctrl.sv
// Sequencer that clears, loads and runs the 4-bit up/down counter for a programmed number of wraps.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic               cp,
  input  logic               clr,
  input  logic               start,
  input  logic               abort,
  input  logic               dir,
  input  logic [WIDTH-1:0]   preset,
  input  logic [WRAP_W-1:0]  wraps,
  output logic [WIDTH-1:0]   cnt_sin,
  output logic               cnt_m,
  output logic               cnt_ld,
  output logic               cnt_clr,
  input  logic [WIDTH-1:0]   cnt_q,
  input  logic               cnt_qcc,
  output logic               busy,
  output logic               done,
  output logic [WRAP_W-1:0]  wrap_cnt,
  output logic [2:0]         state_o
);

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [WIDTH-1:0]    preset_q, preset_d;
  logic [WRAP_W-1:0]   wraps_q, wraps_d;
  logic [WRAP_W-1:0]   wrap_d;
  logic [WIDTH-1:0]    sin_d;
  logic                m_d, ld_d, clr_d, busy_d, done_d;

  // Counter value is observed for status only and never steers the sequence
  logic unused_q;
  assign unused_q = ^cnt_q;

  assign state_o = state_q;

  // State, latched run parameters and registered outputs
  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      preset_q <= '0;
      wraps_q  <= '0;
      wrap_cnt <= '0;
      cnt_sin  <= '0;
      cnt_m    <= IDLE_M;
      cnt_ld   <= IDLE_LD;
      cnt_clr  <= IDLE_CLR;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      preset_q <= preset_d;
      wraps_q  <= wraps_d;
      wrap_cnt <= wrap_d;
      cnt_sin  <= sin_d;
      cnt_m    <= m_d;
      cnt_ld   <= ld_d;
      cnt_clr  <= clr_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state, wrap counting, and output levels for the state being entered
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    preset_d = preset_q;
    wraps_d  = wraps_q;
    wrap_d   = wrap_cnt;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          dir_d    = dir;
          preset_d = preset;
          wraps_d  = wraps;
          wrap_d   = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = abort ? S_IDLE : S_LOAD;
      S_LOAD:  state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!cnt_qcc) begin
          // A target of zero compares against all-ones, giving 2^WRAP_W wraps
          if (wrap_cnt == WRAP_W'(wraps_q - WRAP_W'(1))) begin
            state_d = S_DONE;
          end else begin
            wrap_d = WRAP_W'(wrap_cnt + WRAP_W'(1));
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    sin_d  = '0;
    m_d    = IDLE_M;
    ld_d   = IDLE_LD;
    clr_d  = IDLE_CLR;
    busy_d = 1'b0;
    done_d = 1'b0;

    case (state_d)
      S_CLEAR: begin
        clr_d  = 1'b0;
        busy_d = 1'b1;
      end
      S_LOAD: begin
        ld_d   = 1'b0;
        sin_d  = preset_d;
        busy_d = 1'b1;
      end
      S_RUN: begin
        m_d    = dir_d;
        busy_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl wired to a behavioural model of the 4-bit up/down counter.
module tb_counter_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned WW = 4;

  logic          cp = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dir = 1'b0;
  logic [W-1:0]  preset = '0;
  logic [WW-1:0] wraps = '0;
  logic [W-1:0]  cnt_sin;
  logic          cnt_m, cnt_ld, cnt_clr;
  logic [W-1:0]  cnt_q = '0;
  logic          cnt_qcc = 1'b1;
  logic          busy, done;
  logic [WW-1:0] wrap_cnt;
  logic [2:0]    state_o;

  int total = 0;
  int bad = 0;

  always #5 cp = ~cp;

  counter_ctrl dut (
    .cp(cp), .clr(clr), .start(start), .abort(abort), .dir(dir),
    .preset(preset), .wraps(wraps), .cnt_sin(cnt_sin), .cnt_m(cnt_m),
    .cnt_ld(cnt_ld), .cnt_clr(cnt_clr), .cnt_q(cnt_q), .cnt_qcc(cnt_qcc),
    .busy(busy), .done(done), .wrap_cnt(wrap_cnt), .state_o(state_o)
  );

  // Counter: sync clear, sync load, registered active-low carry on wrap
  always @(posedge cp) begin
    if (!cnt_clr) begin
      cnt_q <= '0; cnt_qcc <= 1'b1;
    end else if (!cnt_ld) begin
      cnt_q <= cnt_sin; cnt_qcc <= 1'b1;
    end else if (cnt_m) begin
      cnt_q <= W'(cnt_q + 1); cnt_qcc <= !(cnt_q == 4'd15);
    end else begin
      cnt_q <= W'(cnt_q - 1); cnt_qcc <= !(cnt_q == 4'd0);
    end
  end

  // Edge (after the start-sampling edge 0) on which done is visible
  function automatic int exp_done_edge(input int p, input bit d, input int n);
    int nn;
    nn = (n == 0) ? 16 : n;
    return d ? (19 - p + 16 * (nn - 1)) : (p + 4 + 16 * (nn - 1));
  endfunction

  task automatic test_reset();
    #12;
    total++;
    if (state_o !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || wrap_cnt !== '0 ||
        cnt_clr !== 1'b1 || cnt_ld !== 1'b1 || cnt_m !== 1'b1 || cnt_sin !== '0) begin
      bad++;
      $display("FAIL reset: st=%0d busy=%b done=%b wc=%0d clr=%b ld=%b m=%b sin=%0d need 0 0 0 0 1 1 1 0",
               state_o, busy, done, wrap_cnt, cnt_clr, cnt_ld, cnt_m, cnt_sin);
    end
    @(negedge cp); clr = 1'b1;
  endtask

  task automatic do_run(input int p, input bit d, input int n, input bit mid_start, input string tag);
    int done_edge, carries, nn, exp_e;
    logic [WW-1:0] exp_w;
    done_edge = -1; carries = 0;
    nn = (n == 0) ? 16 : n;
    exp_e = exp_done_edge(p, d, n);
    exp_w = WW'(nn - 1);
    @(negedge cp);
    preset = W'(p); dir = d; wraps = WW'(n); start = 1'b1;
    @(posedge cp); #1;
    start = 1'b0; preset = W'($urandom); dir = 1'($urandom); wraps = WW'($urandom);
    total++;
    if (state_o !== 3'd1 || busy !== 1'b1 || cnt_clr !== 1'b0) begin
      bad++;
      $display("FAIL %s clear: st=%0d busy=%b clr=%b need 1 1 0", tag, state_o, busy, cnt_clr);
    end
    for (int e = 1; e <= 320 && done_edge < 0; e++) begin
      @(posedge cp); #1;
      if (mid_start) begin
        start = (e == 12);
        if (e == 12) preset = W'(p + 7);
      end
      if (e == 1) begin
        total++;
        if (state_o !== 3'd2 || cnt_ld !== 1'b0 || cnt_sin !== W'(p)) begin
          bad++;
          $display("FAIL %s load: st=%0d ld=%b sin=%0d need 2 0 %0d", tag, state_o, cnt_ld, cnt_sin, p);
        end
      end
      if (e == 2) begin
        total++;
        if (state_o !== 3'd3 || cnt_m !== d || busy !== 1'b1 || cnt_q !== W'(p)) begin
          bad++;
          $display("FAIL %s run: st=%0d m=%b busy=%b q=%0d need 3 %b 1 %0d", tag, state_o, cnt_m, busy, cnt_q, d, p);
        end
      end
      if (done === 1'b1) begin
        done_edge = e;
        total++;
        if (wrap_cnt !== exp_w || busy !== 1'b0 || carries != nn || state_o !== 3'd4) begin
          bad++;
          $display("FAIL %s at done: wc=%0d busy=%b carries=%0d st=%0d need %0d 0 %0d 4",
                   tag, wrap_cnt, busy, carries, state_o, exp_w, nn);
        end
      end else if (state_o == 3'd3 && cnt_qcc == 1'b0) begin
        carries++;
      end
    end
    start = 1'b0;
    total++;
    if (done_edge != exp_e) begin
      bad++;
      $display("FAIL %s done edge: got %0d need %0d", tag, done_edge, exp_e);
    end
    @(posedge cp); #1;
    total++;
    if (state_o !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after done: st=%0d done=%b busy=%b need 0 0 0", tag, state_o, done, busy);
    end
  endtask

  task automatic test_abort_run();
    int carries;
    bit hit;
    carries = 0; hit = 1'b0;
    @(negedge cp);
    preset = 4'd5; dir = 1'b1; wraps = 4'd3; start = 1'b1;
    @(posedge cp); #1; start = 1'b0;
    for (int e = 1; e <= 100 && !hit; e++) begin
      @(posedge cp); #1;
      if (state_o == 3'd3 && cnt_qcc == 1'b0) begin
        carries++;
        if (carries == 2) begin
          abort = 1'b1; hit = 1'b1;
        end
      end
    end
    @(posedge cp); #1;
    abort = 1'b0;
    total++;
    if (!hit || state_o !== 3'd0 || done !== 1'b0 || wrap_cnt !== 4'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_run: hit=%b st=%0d done=%b wc=%0d busy=%b need 1 0 0 1 0",
               hit, state_o, done, wrap_cnt, busy);
    end
    hit = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(posedge cp); #1;
      if (done === 1'b1 || state_o !== 3'd0) hit = 1'b1;
    end
    total++;
    if (hit) begin
      bad++;
      $display("FAIL abort_quiet: activity after abort got 1 need 0");
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge cp);
    preset = 4'd3; dir = 1'b1; wraps = 4'd1; start = 1'b1; abort = 1'b1;
    @(posedge cp); #1;
    total++;
    if (state_o !== 3'd0 || busy !== 1'b0 || cnt_clr !== 1'b1) begin
      bad++;
      $display("FAIL start_abort_idle: st=%0d busy=%b clr=%b need 0 0 1", state_o, busy, cnt_clr);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset_in_load();
    @(negedge cp);
    preset = 4'd9; dir = 1'b0; wraps = 4'd1; start = 1'b1;
    @(posedge cp); #1; start = 1'b0;
    @(posedge cp); #1;
    total++;
    if (state_o !== 3'd2) begin
      bad++;
      $display("FAIL rst_load pre: st=%0d need 2", state_o);
    end
    #2 clr = 1'b0;
    #1;
    total++;
    if (state_o !== 3'd0 || busy !== 1'b0 || cnt_ld !== 1'b1 || cnt_clr !== 1'b1 || wrap_cnt !== '0) begin
      bad++;
      $display("FAIL rst_load: st=%0d busy=%b ld=%b clr=%b wc=%0d need 0 0 1 1 0",
               state_o, busy, cnt_ld, cnt_clr, wrap_cnt);
    end
    @(negedge cp); clr = 1'b1;
    do_run(9, 1'b0, 1, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      do_run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset();
    do_run(14, 1'b1, 1, 1'b0, "up_single");
    do_run(0, 1'b0, 2, 1'b0, "down_zero");
    do_run(0, 1'b1, 0, 1'b0, "sixteen");
    test_abort_run();
    test_start_abort_idle();
    do_run(3, 1'b1, 2, 1'b1, "start_busy");
    test_reset_in_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
